// File: rtl/decoder.sv
// Token decoder: walks a 0-terminated code stream, looks each code up in the code table,
// and copies the matching vocabulary token to the output memory. Build option: DECODER_ERR_EN.
module decoder #(
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned VOCAB_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    output logic                        done,
    output logic                        err,
    output logic [ADDR_WIDTH-1:0]       code_addr,
    input  logic [DATA_WIDTH-1:0]       code_dout,
    output logic [VOCAB_ADDR_WIDTH-1:0] table_addr,
    input  logic [DATA_WIDTH-1:0]       table_dout,
    output logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0]       vocab_dout,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    output logic [DATA_WIDTH-1:0]       out_din,
    output logic                        out_we
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] C_REQ = 4'd1;
    localparam logic [3:0] C_CHK = 4'd2;
    localparam logic [3:0] T_REQ = 4'd3;
    localparam logic [3:0] T_CHK = 4'd4;
    localparam logic [3:0] S_REQ = 4'd5;
    localparam logic [3:0] S_CHK = 4'd6;
    localparam logic [3:0] V_REQ = 4'd7;
    localparam logic [3:0] V_CHK = 4'd8;
    localparam logic [3:0] MISS  = 4'd9;
    localparam logic [3:0] TERM  = 4'd10;
    localparam logic [3:0] DONE  = 4'd11;

    localparam logic [ADDR_WIDTH-1:0]       A_ONE = ADDR_WIDTH'(1);
    localparam logic [VOCAB_ADDR_WIDTH-1:0] V_ONE = VOCAB_ADDR_WIDTH'(1);

    logic [3:0]                  state, state_n;
    logic [ADDR_WIDTH-1:0]       a_code, a_code_n;
    logic [ADDR_WIDTH-1:0]       a_out, a_out_n;
    logic [VOCAB_ADDR_WIDTH-1:0] a_tab, a_tab_n;
    logic [VOCAB_ADDR_WIDTH-1:0] a_voc, a_voc_n;
    logic [VOCAB_ADDR_WIDTH-1:0] idx, idx_n;
    logic [VOCAB_ADDR_WIDTH-1:0] skip_cnt, skip_cnt_n;
    logic [DATA_WIDTH-1:0]       code_r, code_r_n;
    logic                        done_n, err_n, out_we_n;
    logic [ADDR_WIDTH-1:0]       out_addr_n;
    logic [DATA_WIDTH-1:0]       out_din_n;

    // Memory read addresses come straight from the walking address registers.
    assign code_addr  = a_code;
    assign table_addr = a_tab;
    assign vocab_addr = a_voc;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_code   <= '0;
            a_out    <= '0;
            a_tab    <= '0;
            a_voc    <= '0;
            idx      <= '0;
            skip_cnt <= '0;
            code_r   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_din  <= '0;
        end else begin
            state    <= state_n;
            a_code   <= a_code_n;
            a_out    <= a_out_n;
            a_tab    <= a_tab_n;
            a_voc    <= a_voc_n;
            idx      <= idx_n;
            skip_cnt <= skip_cnt_n;
            code_r   <= code_r_n;
            done     <= done_n;
            err      <= err_n;
            out_we   <= out_we_n;
            out_addr <= out_addr_n;
            out_din  <= out_din_n;
        end
    end

    // Next state and next register values; write strobes are prepared one cycle ahead.
    always_comb begin
        state_n    = state;
        a_code_n   = a_code;
        a_out_n    = a_out;
        a_tab_n    = a_tab;
        a_voc_n    = a_voc;
        idx_n      = idx;
        skip_cnt_n = skip_cnt;
        code_r_n   = code_r;
        done_n     = done;
        err_n      = err;
        out_we_n   = 1'b0;
        out_addr_n = out_addr;
        out_din_n  = out_din;

        case (state)
            IDLE: begin
                if (cs) state_n = C_REQ;
            end
            C_REQ: state_n = C_CHK;
            C_CHK: begin
                if (code_dout == '0) begin
                    out_we_n   = 1'b1;
                    out_din_n  = '0;
                    out_addr_n = a_out;
                    state_n    = TERM;
                end else begin
                    code_r_n = code_dout;
                    a_tab_n  = '0;
                    state_n  = T_REQ;
                end
            end
            T_REQ: state_n = T_CHK;
            T_CHK: begin
                if (table_dout == code_r) begin
                    idx_n      = a_tab;
                    a_voc_n    = '0;
                    skip_cnt_n = '0;
                    state_n    = (a_tab == '0) ? V_REQ : S_REQ;
                end else if (a_tab == '1) begin
                    state_n = MISS;
                end else begin
                    a_tab_n = a_tab + V_ONE;
                    state_n = T_REQ;
                end
            end
            S_REQ: state_n = S_CHK;
            S_CHK: begin
                // Count token terminators until idx tokens have been passed.
                a_voc_n = a_voc + V_ONE;
                state_n = S_REQ;
                if (vocab_dout == '0) begin
                    skip_cnt_n = skip_cnt + V_ONE;
                    if ((skip_cnt + V_ONE) == idx) state_n = V_REQ;
                end
            end
            V_REQ: state_n = V_CHK;
            V_CHK: begin
                if (vocab_dout != '0) begin
                    out_we_n   = 1'b1;
                    out_din_n  = vocab_dout;
                    out_addr_n = a_out;
                    a_voc_n    = a_voc + V_ONE;
`ifdef DECODER_ERR_EN
                    // The character that would wrap the output is replaced by the terminator.
                    if (a_out == '1) begin
                        err_n     = 1'b1;
                        out_din_n = '0;
                        state_n   = TERM;
                    end else begin
                        a_out_n = a_out + A_ONE;
                        state_n = V_REQ;
                    end
`else
                    a_out_n = a_out + A_ONE;
                    state_n = V_REQ;
`endif
                end else begin
                    a_code_n = a_code + A_ONE;
                    state_n  = C_REQ;
                end
            end
            MISS: begin
`ifdef DECODER_ERR_EN
                err_n = 1'b1;
`endif
                a_code_n = a_code + A_ONE;
                state_n  = C_REQ;
            end
            TERM: begin
                done_n  = 1'b1;
                state_n = DONE;
            end
            DONE: state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed vectors, reset/hold sequences and random
// streams checked against a search-based reference model.
module tb_decoder;

    localparam int unsigned AW    = 4;
    localparam int unsigned VW    = 4;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 16;
`ifdef DECODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic          done;
    logic          err;
    logic [AW-1:0] code_addr;
    logic [DW-1:0] code_dout;
    logic [VW-1:0] table_addr;
    logic [DW-1:0] table_dout;
    logic [VW-1:0] vocab_addr;
    logic [DW-1:0] vocab_dout;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_din;
    logic          out_we;

    decoder #(.ADDR_WIDTH(AW), .VOCAB_ADDR_WIDTH(VW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .done       (done),
        .err        (err),
        .code_addr  (code_addr),
        .code_dout  (code_dout),
        .table_addr (table_addr),
        .table_dout (table_dout),
        .vocab_addr (vocab_addr),
        .vocab_dout (vocab_dout),
        .out_addr   (out_addr),
        .out_din    (out_din),
        .out_we     (out_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] code_mem  [DEPTH];
    logic [7:0] tab_mem   [DEPTH];
    logic [7:0] vocab_mem [DEPTH];
    logic [7:0] out_mem   [DEPTH];
    logic       clr;
    int         wr_cnt;

    always @(posedge clk) begin
        code_dout  <= code_mem[code_addr];
        table_dout <= tab_mem[table_addr];
        vocab_dout <= vocab_mem[vocab_addr];
        if (clr) begin
            for (int j = 0; j < DEPTH; j++) out_mem[j] <= 8'hAA;
            wr_cnt <= 0;
        end else if (out_we) begin
            out_mem[out_addr] <= out_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] code;     // byte k at [8k+:8]
        logic [63:0] tab;
        logic [63:0] voc;
        logic [63:0] exp_out;
        int          exp_len;
        bit          miss;     // stream holds an unknown code
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    logic [7:0] m_out [DEPTH];
    int         m_wr;
    int         m_lat;
    bit         m_err;

    // Reference: search table, locate token by counting terminators, copy bytes.
    task automatic model();
        int         a_out, pos, i, start, k;
        bit         ovf;
        logic [7:0] c;
        for (int j = 0; j < DEPTH; j++) m_out[j] = 8'hAA;
        m_wr = 0; m_err = 1'b0; m_lat = 0; a_out = 0; ovf = 1'b0;
        for (pos = 0; pos < DEPTH && !ovf; pos++) begin
            c = code_mem[pos];
            m_lat += 2;
            if (c == 8'h00) break;
            i = -1;
            for (int t = 0; t < DEPTH; t++) begin
                if (tab_mem[t] == c) begin
                    i = t;
                    break;
                end
            end
            if (i < 0) begin
                m_lat += 2 * DEPTH + 1;
                if (ERR_EN) m_err = 1'b1;
                continue;
            end
            m_lat += 2 * (i + 1);
            start = 0;
            for (int z = 0; z < i; z++) begin
                while (start < DEPTH && vocab_mem[start] != 8'h00) start++;
                start++;
            end
            m_lat += 2 * start;
            k = start;
            while (1) begin
                m_lat += 2;
                if (vocab_mem[k % DEPTH] == 8'h00) break;
                if (ERR_EN && a_out == DEPTH - 1) begin
                    ovf = 1'b1;
                    m_err = 1'b1;
                    break;
                end
                m_out[a_out] = vocab_mem[k % DEPTH];
                m_wr++;
                a_out = (a_out + 1) % DEPTH;
                k++;
            end
        end
        m_out[a_out] = 8'h00;
        m_wr++;
        m_lat += 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cs = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; rst_n = 1'b1;
    endtask

    task automatic clear_mems();
        for (int j = 0; j < DEPTH; j++) begin
            code_mem[j] = 8'h00; tab_mem[j] = 8'h00; vocab_mem[j] = 8'h00;
        end
    endtask

    task automatic load_vec(input vec_t v);
        clear_mems();
        for (int j = 0; j < 8; j++) begin
            code_mem[j]  = v.code[8*j +: 8];
            tab_mem[j]   = v.tab[8*j +: 8];
            vocab_mem[j] = v.voc[8*j +: 8];
        end
    endtask

    // Pulse cs and count rising edges after the cs-sampling edge until done is seen.
    task automatic start_and_wait(input bit hold, output int lat);
        @(negedge clk);
        cs = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        if (!hold) cs = 1'b0;
        while (lat < 3000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        check("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic check_model(input string tag, input int lat);
        model();
        check({tag, "_latency"}, 32'(lat), 32'(m_lat));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_writes"}, 32'(wr_cnt), 32'(m_wr));
        for (int j = 0; j < DEPTH; j++)
            check($sformatf("%s_out%0d", tag, j), 32'(out_mem[j]), 32'(m_out[j]));
    endtask

    initial begin
        int lat;
        int n0;
        int ntok, p, len, ncode;

        rst_n = 1'b0; cs = 1'b0; clr = 1'b1;
        clear_mems();
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_out_din", 32'(out_din), 32'd0);
        check("rst_code_addr", 32'(code_addr), 32'd0);
        check("rst_table_addr", 32'(table_addr), 32'd0);
        check("rst_vocab_addr", 32'(vocab_addr), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);

        //            code                  table                 vocab                 expected out          len miss lat
        vecs[0] = '{64'h0000_0000_0000_1011, 64'h0000_0000_0012_1110, 64'h0000_0063_0062_0061, 64'h0000_0000_0000_6162, 3, 1'b0, 25};
        vecs[1] = '{64'h0000_0000_0000_2021, 64'h0000_0000_0000_2120, 64'h0000_0000_6300_6261, 64'h0000_0000_0062_6163, 4, 1'b0, 29};
        vecs[2] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0012_1110, 64'h0000_0063_0062_0061, 64'h0000_0000_0000_0000, 1, 1'b0, 3};
        vecs[3] = '{64'h0000_0000_0000_1055, 64'h0000_0000_0012_1110, 64'h0000_0063_0062_0061, 64'h0000_0000_0000_0061, 2, 1'b1, 46};
        vecs[4] = '{64'h0000_0000_0000_0030, 64'h0000_0000_0000_3030, 64'h0000_0000_0062_0061, 64'h0000_0000_0000_0061, 2, 1'b0, 11};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_vec(vecs[i]);
            start_and_wait(i == 0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].miss & ERR_EN));
            check($sformatf("v%0d_writes", i), 32'(wr_cnt), 32'(vecs[i].exp_len));
            for (int k = 0; k < vecs[i].exp_len; k++)
                check($sformatf("v%0d_out%0d", i, k), 32'(out_mem[k]), 32'(vecs[i].exp_out[8*k +: 8]));
            if (i == 0) begin
                // cs still high: DONE must hold with no further writes.
                repeat (6) @(negedge clk);
                check("hold_cs_done", 32'(done), 32'd1);
                check("hold_cs_writes", 32'(wr_cnt), 32'd3);
                cs = 1'b0;
            end
        end

        // Reset during V_CHK of the first copied character, then restart without clearing.
        do_reset();
        load_vec(vecs[1]);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        n0 = 0;
        while (!out_we && n0 < 200) begin
            @(negedge clk);
            n0++;
        end
        check("midcopy_saw_write", 32'(out_we), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midcopy_rst_done", 32'(done), 32'd0);
        check("midcopy_rst_out_we", 32'(out_we), 32'd0);
        check("midcopy_rst_code_addr", 32'(code_addr), 32'd0);
        check("midcopy_rst_table_addr", 32'(table_addr), 32'd0);
        check("midcopy_rst_vocab_addr", 32'(vocab_addr), 32'd0);
        check("midcopy_rst_out_addr", 32'(out_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(1'b0, lat);
        check("restart_latency", 32'(lat), 32'd29);
        check("restart_out0", 32'(out_mem[0]), 32'h63);
        check("restart_out1", 32'(out_mem[1]), 32'h61);
        check("restart_out2", 32'(out_mem[2]), 32'h62);
        check("restart_out3", 32'(out_mem[3]), 32'h00);

        // Output overflow: 21 characters into a 16-entry output memory.
        do_reset();
        clear_mems();
        for (int j = 0; j < 7; j++) vocab_mem[j] = 8'(8'h61 + j);
        tab_mem[0] = 8'h05;
        code_mem[0] = 8'h05; code_mem[1] = 8'h05; code_mem[2] = 8'h05;
        start_and_wait(1'b0, lat);
        check("ovf_err_flag", 32'(err), 32'(ERR_EN));
        check_model("ovf", lat);

        // Random streams against the reference model.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            clear_mems();
            p = 0; ntok = 0;
            while (ntok < 6) begin
                len = int'($urandom_range(1, 3));
                if (p + len + 1 > DEPTH) break;
                for (int c = 0; c < len; c++) begin
                    vocab_mem[p] = 8'($urandom_range(97, 122));
                    p++;
                end
                vocab_mem[p] = 8'h00;
                p++;
                ntok++;
            end
            for (int t = 0; t < ntok; t++) tab_mem[t] = 8'($urandom_range(1, 8));
            ncode = int'($urandom_range(0, 7));
            for (int q = 0; q < ncode; q++) begin
                if ($urandom_range(0, 3) == 0) code_mem[q] = 8'($urandom_range(1, 12));
                else code_mem[q] = tab_mem[$urandom_range(0, ntok - 1)];
            end
            code_mem[ncode] = 8'h00;
            start_and_wait(1'b0, lat);
            check_model($sformatf("rnd%0d", r), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
